// File: rtl/pool_stream.sv
// Streaming pooling unit: reduces every WIN valid samples to one max/average value and
// packs LANES pooled values into a vector, pulsing out_valid when the vector completes.
module pool_stream #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WIN    = 4,
  parameter int unsigned LANES  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          mode,
  input  logic                          flush,
  output logic [LANES-1:0][DATA_W-1:0]  pooled_out,
  output logic                          out_valid,
  output logic                          busy
);

  localparam int unsigned ShiftW = $clog2(WIN);
  localparam int unsigned AccW   = DATA_W + ShiftW;
  localparam int unsigned CntW   = (ShiftW > 0) ? ShiftW : 1;
  localparam int unsigned LaneW  = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [CntW-1:0]  CntMax  = CntW'(WIN - 1);
  localparam logic [LaneW-1:0] LaneMax = LaneW'(LANES - 1);

  logic [CntW-1:0]                 cnt_q, cnt_d;
  logic [LaneW-1:0]                lane_q, lane_d;
  logic [AccW-1:0]                 acc_q, acc_d;
  logic                            mode_q, mode_d;
  logic [LANES-1:0][DATA_W-1:0]    stage_q, stage_d;
  logic [LANES-1:0][DATA_W-1:0]    pooled_q, pooled_d;
  logic                            valid_q, valid_d;

  logic [AccW-1:0]   in_ext;
  logic [AccW-1:0]   win_sum;
  logic [AccW-1:0]   win_max;
  logic [DATA_W-1:0] win_avg;
  logic [DATA_W-1:0] win_res;

  assign in_ext  = AccW'(in_data);
  assign win_sum = acc_q + in_ext;
  assign win_max = (acc_q > in_ext) ? acc_q : in_ext;
  // Sum of WIN DATA_W-bit samples fits AccW, so the shift truncates without overflow.
  assign win_avg = DATA_W'(win_sum >> ShiftW);
  assign win_res = mode_q ? win_avg : win_max[DATA_W-1:0];

  always_comb begin
    cnt_d    = cnt_q;
    lane_d   = lane_q;
    acc_d    = acc_q;
    mode_d   = mode_q;
    stage_d  = stage_q;
    pooled_d = pooled_q;
    valid_d  = 1'b0;

    if (flush) begin
      cnt_d   = '0;
      lane_d  = '0;
      stage_d = '0;
    end else if (in_valid) begin
      if (cnt_q == '0) begin
        acc_d  = in_ext;
        mode_d = mode;
      end else begin
        acc_d = mode_q ? win_sum : win_max;
      end

      if (cnt_q == CntMax) begin
        cnt_d           = '0;
        stage_d[lane_q] = win_res;
        if (lane_q == LaneMax) begin
          pooled_d = stage_d;
          valid_d  = 1'b1;
          lane_d   = '0;
        end else begin
          lane_d = lane_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      lane_q   <= '0;
      acc_q    <= '0;
      mode_q   <= 1'b0;
      stage_q  <= '0;
      pooled_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      lane_q   <= lane_d;
      acc_q    <= acc_d;
      mode_q   <= mode_d;
      stage_q  <= stage_d;
      pooled_q <= pooled_d;
      valid_q  <= valid_d;
    end
  end

  assign pooled_out = pooled_q;
  assign out_valid  = valid_q;
  assign busy       = (cnt_q != '0) || (lane_q != '0);

endmodule

// File: tb/tb_pool_stream.sv
// Directed bench for pool_stream with default parameters (DATA_W=8, WIN=4, LANES=4).
module tb_pool_stream;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = '0;
  logic             mode = 1'b0;
  logic             flush = 1'b0;
  logic [3:0][7:0]  pooled_out;
  logic             out_valid;
  logic             busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] samples [16] = '{8'h31, 8'h32, 8'h38, 8'h07, 8'h01, 8'h00, 8'h33, 8'hFC,
                               8'h10, 8'h20, 8'h30, 8'h40, 8'hFF, 8'h00, 8'h00, 8'h00};

  pool_stream #(.DATA_W(8), .WIN(4), .LANES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .mode       (mode),
    .flush      (flush),
    .pooled_out (pooled_out),
    .out_valid  (out_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One valid sample captured on the next rising edge; returns #1 after that edge.
  task automatic push(input logic [7:0] d, input logic m);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    mode     = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_vector(input string tag, input logic m, input int gap_max,
                            input logic [31:0] exp);
    for (int i = 0; i < 16; i++) begin
      push(samples[i], m);
      if (i == 14) begin
        check({tag, "_valid_pre"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_busy_pre"}, {31'd0, busy}, 32'd1);
      end
      if (gap_max > 0 && i < 15) idle($urandom_range(1, gap_max));
    end
    check({tag, "_pooled"}, pooled_out, exp);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    idle(1);
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_hold"}, pooled_out, exp);
  endtask

  initial begin
    #12;
    check("reset_pooled", pooled_out, 32'h0);
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_vector("max", 1'b0, 0, 32'hFF40FC38);
    run_vector("avg", 1'b1, 0, 32'h3F284C28);

    // Reset mid-window between edges; effect must be immediate.
    for (int i = 0; i < 5; i++) push(8'hFF, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_pooled", pooled_out, 32'h0);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vector("postrst", 1'b0, 0, 32'hFF40FC38);

    run_vector("bubble", 1'b0, 3, 32'hFF40FC38);

    // Mode changes mid-window: window 0 stays average, later windows max.
    push(8'h31, 1'b1);
    push(8'h32, 1'b1);
    push(8'h38, 1'b0);
    push(8'h07, 1'b0);
    for (int i = 4; i < 16; i++) push(samples[i], 1'b0);
    check("latch_lane0", {24'd0, pooled_out[0]}, 32'h28);
    check("latch_lane1", {24'd0, pooled_out[1]}, 32'hFC);
    check("latch_vec", pooled_out, 32'hFF40FC28);
    check("latch_valid", {31'd0, out_valid}, 32'd1);

    // Flush after 6 samples, with a colliding sample that must be dropped.
    for (int i = 0; i < 6; i++) push(8'hAA, 1'b1);
    check("preflush_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    mode     = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_pooled", pooled_out, 32'hFF40FC28);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    run_vector("postflush", 1'b0, 0, 32'hFF40FC38);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pool_stream.md
# pool_stream

Parametrised streaming pooling unit; generalises the fixed 8-bit, 4-output pooling stage that follows the convolution engine. It consumes one convolution result per valid cycle and reduces every WIN consecutive valid samples to one pooled value, using max or average selected per window. It packs LANES pooled values into an output vector and pulses `out_valid` when the vector is complete. It adds what the earlier stage lacked: runtime mode select, bubble tolerance, flush, and an explicit completion strobe.

## Interface
- `DATA_W`, default 8: sample and pooled-value width, unsigned.
- `WIN`, default 4: samples per pooling window; power of two, ≥2.
- `LANES`, default 4: pooled values per output vector; ≥1.

- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: `in_data` is captured on this edge.
- `in_data` input, DATA_W bits: convolution result.
- `mode` input, 1 bit: 0 = max, 1 = average. Sampled only on the first sample of a window.
- `flush` input, 1 bit: synchronous discard of the partial window and partial vector.
- `pooled_out` output, LANES×DATA_W bits (`[LANES-1:0][DATA_W-1:0]`): last completed vector. Lane 0 holds the first window.
- `out_valid` output, 1 bit: one-cycle pulse when `pooled_out` has just been updated.
- `busy` output, 1 bit: high when the sample count ≠ 0 or the lane index ≠ 0.

## Operation
- **State:**
  - sample counter `cnt`, range 0..WIN-1
  - lane index `lane`, range 0..LANES-1
  - accumulator `acc`, width DATA_W+log2(WIN)
  - latched mode `mode_q`
  - staging vector `stage[LANES]`
  - output register `pooled_out`
- **In-window accumulate** (`in_valid`=1, `flush`=0):
  - If `cnt`==0: `acc`←`in_data`, `mode_q`←`mode`.
  - Otherwise: `acc`←max(`acc`,`in_data`) in max mode, or `acc`+`in_data` in average mode.
  - `cnt` increments.
- **Window close** (`cnt`==WIN-1 with a valid sample):
  - Result is max(`acc`,`in_data`) in max mode.
  - In average mode the result is (`acc`+`in_data`)>>log2(WIN): truncating, no rounding. The sum never overflows the `acc` width.
  - The result is written to `stage[lane]`, `cnt`←0, and `lane` increments.
- **Vector close** (window close with `lane`==LANES-1):
  - `pooled_out`←`stage` with the final result substituted into lane LANES-1.
  - `out_valid`←1, `lane`←0.
- **Bubbles:** `in_valid`=0 holds all state. Gaps of any length do not change the results.
- **Mode changes:** a `mode` change inside a window has no effect until the next window starts. Lanes within one vector may use different modes.
- **Flush:**
  - `flush`=1 clears `cnt`, `lane` and `stage`, and sets `out_valid`←0.
  - `pooled_out` keeps its last completed value.
  - If `flush` and `in_valid` are both high, flush wins and the sample is dropped.
- **Reset** (asynchronous, any time, including mid-window):
  - `pooled_out`=0, `out_valid`=0, `busy`=0, `cnt`=0, `lane`=0, `acc`=0, `stage`=0, `mode_q`=0.
  - The first valid sample after `rst_n` deasserts starts a new window.

## Timing
- Inputs are sampled on the rising edge. All outputs are registered, with no combinational input-to-output path.
- **Output latency:** `pooled_out` and `out_valid` change on the same edge that captures the WIN×LANES-th valid sample of a vector. They are visible from then until the next edge.
- **`out_valid`** is high for exactly one cycle per completed vector. It cannot be high in consecutive cycles unless WIN×LANES==1, which the parameter constraints rule out.
- **Throughput:** one sample per cycle with no stalls. No backpressure exists, so downstream logic must accept `pooled_out` within WIN×LANES cycles.
- **`busy`** reflects the post-edge state: it is 0 after a vector close, a flush or a reset.

## Test plan
All scenarios use the defaults DATA_W=8, WIN=4, LANES=4.

1. **Reset state:** assert `rst_n`=0 mid-stream, between clock edges → `pooled_out`=0, `out_valid`=0 and `busy`=0 immediately. After release, 16 valid samples produce a correct vector with no contribution from pre-reset data.
2. **Max mode, back-to-back:** `mode`=0, samples 31,32,38,07, 01,00,33,FC, 10,20,30,40, FF,00,00,00 (hex) → on the 16th edge `pooled_out`={FF,40,FC,38} (lane3..lane0). `out_valid` is high for that one cycle only.
3. **Average mode, same samples:** `mode`=1 → `pooled_out`={3F,28,4C,28}. 0x4C=304/4; 0x3F=255/4, truncated.
4. **Bubbles:** repeat scenario 2 with `in_valid` low for 1–3 random cycles between samples → identical `pooled_out`. `out_valid` pulses on the edge capturing the 16th valid sample.
5. **Mode latch:** window 0 starts with `mode`=1 and `mode` is set to 0 after its 2nd sample → lane0=0x28 (average). Window 1, started with `mode`=0, gives lane1=0xFC.
6. **Flush:**
   - Run 6 valid samples, then assert `flush` together with `in_valid` → `busy`=0, `pooled_out` unchanged, and the flush-cycle sample is dropped.
   - The next 16 samples give a vector that depends only on those samples.
